// File: rtl/fetch_pipe_reg_if.sv
// Fetch-stage bus between the hazard/fetch environment and fetch_pipe_reg.
// Purpose: bundles the PC-control inputs, the instruction-memory read data
// and the PC / IF/ID / counter outputs into one port.
// Signals:
//   keep_pc        1      hold the PC this cycle
//   hazard_if_id   2      IF/ID control: 00 normal, 01 flush, 10/11 stall
//   branch_taken   1      redirect to branch_target
//   branch_target  32     branch destination
//   jump           1      redirect to jump_target
//   jump_target    32     jump destination
//   imem_instr     32     instruction memory data at the current pc
//   pc             32     current fetch address
//   if_id_instr    32     latched instruction for decode
//   if_id_pc4      32     latched pc+4 of that instruction
//   if_id_valid    1      IF/ID holds a real instruction
//   stall_cnt      CNT_W  saturating stall-cycle count
//   flush_cnt      CNT_W  saturating flush-cycle count
// Modports: master = environment side, slave = fetch_pipe_reg.
interface fetch_pipe_reg_if #(
  parameter int CNT_W = 16
);
  logic             keep_pc;
  logic [1:0]       hazard_if_id;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             jump;
  logic [31:0]      jump_target;
  logic [31:0]      imem_instr;
  logic [31:0]      pc;
  logic [31:0]      if_id_instr;
  logic [31:0]      if_id_pc4;
  logic             if_id_valid;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output keep_pc, hazard_if_id, branch_taken, branch_target,
           jump, jump_target, imem_instr,
    input  pc, if_id_instr, if_id_pc4, if_id_valid, stall_cnt, flush_cnt
  );

  modport slave (
    input  keep_pc, hazard_if_id, branch_taken, branch_target,
           jump, jump_target, imem_instr,
    output pc, if_id_instr, if_id_pc4, if_id_valid, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fetch_pipe_reg.sv
// PC register plus IF/ID pipeline register.
// Purpose: applies keep_pc to the PC and the hazard code to the IF/ID latch,
// selects the next PC (hold > branch > jump > pc+4), and keeps saturating
// stall/flush event counters for performance debug.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   fetch_if  fetch_pipe_reg_if.slave (controls in; pc, IF/ID, counters out)
// All outputs come straight from flops.
module fetch_pipe_reg #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_pipe_reg_if.slave  fetch_if
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [31:0]      pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    // A branch arriving while the PC is held is dropped; the hazard unit
    // re-presents it once the hold clears.
    if (fetch_if.keep_pc)           pc_d = pc_q;
    else if (fetch_if.branch_taken) pc_d = fetch_if.branch_target;
    else if (fetch_if.jump)         pc_d = fetch_if.jump_target;
    else                            pc_d = pc_plus4;
    pc_d[1:0] = 2'b00;

    // IF/ID is steered only by the hazard code, never by keep_pc.
    unique case (fetch_if.hazard_if_id)
      2'b00: begin
        instr_d = fetch_if.imem_instr;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
      2'b01: begin
        instr_d = NOP_INSTR;
        pc4_d   = 32'h0;
        valid_d = 1'b0;
        if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
      default: begin
        // 10 stall and 11 (illegal, treated as stall): IF/ID holds.
        if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      pc4_q       <= 32'h0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fetch_if.pc          = pc_q;
  assign fetch_if.if_id_instr = instr_q;
  assign fetch_if.if_id_pc4   = pc4_q;
  assign fetch_if.if_id_valid = valid_q;
  assign fetch_if.stall_cnt   = stall_cnt_q;
  assign fetch_if.flush_cnt   = flush_cnt_q;

endmodule
